// File: rtl/axi_rd_responder.sv
// AXI4 read-channel responder (AR/R slave).
// Incoming AR requests are queued in a small in-order FIFO. Each burst is
// served after a programmable start latency, fetching one beat per SRAM read
// (1-cycle read latency) and presenting it on R until accepted.
module axi_rd_responder #(
    parameter int ADDR_BITS            = 64,
    parameter int LOG_BLOCK_DATA_BYTES = 6,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int TID_WIDTH            = 8,
    parameter int LOG_QUEUE_DEPTH      = 2,
    parameter int LAT_WIDTH            = 8
) (
    input  logic                                        clk,
    input  logic                                        resetN,
    // AR channel
    input  logic                                        s_ar_valid,
    output logic                                        s_ar_ready,
    input  logic [ADDR_BITS-1:0]                        s_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0]                  s_ar_len,
    input  logic [TID_WIDTH-1:0]                        s_ar_id,
    // R channel
    output logic                                        s_r_valid,
    input  logic                                        s_r_ready,
    output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]        s_r_data,
    output logic [TID_WIDTH-1:0]                        s_r_id,
    output logic                                        s_r_last,
    // block SRAM read port
    output logic                                        mem_rd_en,
    output logic [ADDR_BITS-LOG_BLOCK_DATA_BYTES-1:0]   mem_rd_addr,
    input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]        mem_rd_data,
    // control / status
    input  logic [LAT_WIDTH-1:0]                        respLatency,
    output logic [LOG_QUEUE_DEPTH:0]                    queueCnt,
    output logic                                        busy
);

    localparam int DEPTH = 1 << LOG_QUEUE_DEPTH;
    localparam logic [LOG_QUEUE_DEPTH:0] DEPTH_CNT  = (LOG_QUEUE_DEPTH+1)'(DEPTH);
    localparam logic [ADDR_BITS-1:0]     BEAT_BYTES = ADDR_BITS'(1 << LOG_BLOCK_DATA_BYTES);

    typedef enum logic [2:0] {
        st_idle,
        st_wait,
        st_fetch,
        st_capture,
        st_resp
    } state_t;

    // ------------------------------------------------------------------
    // Outstanding-request FIFO
    // ------------------------------------------------------------------
    logic [ADDR_BITS-1:0]       q_addr_mem [DEPTH];
    logic [BURST_LEN_WIDTH-1:0] q_len_mem  [DEPTH];
    logic [TID_WIDTH-1:0]       q_id_mem   [DEPTH];

    logic [LOG_QUEUE_DEPTH-1:0] wr_ptr_reg;
    logic [LOG_QUEUE_DEPTH-1:0] rd_ptr_reg;
    logic [LOG_QUEUE_DEPTH:0]   q_cnt_reg;
    logic                       ar_open_reg;
    logic [DEPTH-1:0]           wr_sel;
    logic                       push;
    logic                       pop;

    logic [ADDR_BITS-1:0]       head_addr;
    logic [BURST_LEN_WIDTH-1:0] head_len;
    logic [TID_WIDTH-1:0]       head_id;

    // ------------------------------------------------------------------
    // Burst engine state
    // ------------------------------------------------------------------
    state_t                     state_reg;
    logic [ADDR_BITS-1:0]       cur_addr_reg;
    logic [ADDR_BITS-1:0]       cur_addr_next;
    logic [BURST_LEN_WIDTH-1:0] beats_left_reg;
    logic [TID_WIDTH-1:0]       cur_id_reg;
    logic [LAT_WIDTH-1:0]       wait_cnt_reg;

    // Ready is decoded from the registered count only, so a full queue refuses
    // a push even when the head is popped in the same cycle. ar_open_reg keeps
    // ready low while reset is asserted.
    assign s_ar_ready = ar_open_reg && (q_cnt_reg != DEPTH_CNT);
    assign push       = s_ar_valid && s_ar_ready;
    assign pop        = (state_reg == st_idle) && (q_cnt_reg != '0);

    assign head_addr  = q_addr_mem[rd_ptr_reg];
    assign head_len   = q_len_mem[rd_ptr_reg];
    assign head_id    = q_id_mem[rd_ptr_reg];

    assign queueCnt   = q_cnt_reg;
    assign busy       = (state_reg != st_idle) || (q_cnt_reg != '0);

    // Next beat address; wraps silently at the top of the address space.
    assign cur_addr_next = cur_addr_reg + BEAT_BYTES;

    // One-hot write select per FIFO entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push && (wr_ptr_reg == LOG_QUEUE_DEPTH'(gi));
        end
    endgenerate

    // FIFO pointers, occupancy and the post-reset AR enable.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            q_cnt_reg   <= '0;
            ar_open_reg <= 1'b0;
        end else begin
            ar_open_reg <= 1'b1;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + LOG_QUEUE_DEPTH'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + LOG_QUEUE_DEPTH'(1);
            end
            if (push && !pop) begin
                q_cnt_reg <= q_cnt_reg + (LOG_QUEUE_DEPTH+1)'(1);
            end else if (pop && !push) begin
                q_cnt_reg <= q_cnt_reg - (LOG_QUEUE_DEPTH+1)'(1);
            end
        end
    end

    // FIFO payload storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                q_addr_mem[i] <= s_ar_addr;
                q_len_mem[i]  <= s_ar_len;
                q_id_mem[i]   <= s_ar_id;
            end
        end
    end

    // Burst FSM: pop, optional latency wait, then fetch/capture/respond per beat.
    // SRAM strobe and all R outputs are registered and set on state entry.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg      <= st_idle;
            cur_addr_reg   <= '0;
            beats_left_reg <= '0;
            cur_id_reg     <= '0;
            wait_cnt_reg   <= '0;
            mem_rd_en      <= 1'b0;
            mem_rd_addr    <= '0;
            s_r_valid      <= 1'b0;
            s_r_data       <= '0;
            s_r_id         <= '0;
            s_r_last       <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            case (state_reg)
                st_idle: begin
                    if (q_cnt_reg != '0) begin
                        cur_addr_reg   <= head_addr;
                        beats_left_reg <= head_len;
                        cur_id_reg     <= head_id;
                        // Latency is sampled here only; later changes leave this burst alone.
                        if (respLatency == '0) begin
                            state_reg   <= st_fetch;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= head_addr[ADDR_BITS-1:LOG_BLOCK_DATA_BYTES];
                        end else begin
                            wait_cnt_reg <= respLatency;
                            state_reg    <= st_wait;
                        end
                    end
                end
                st_wait: begin
                    // Entered with the latency value, leaves on 1: exactly L cycles here.
                    wait_cnt_reg <= wait_cnt_reg - LAT_WIDTH'(1);
                    if (wait_cnt_reg == LAT_WIDTH'(1)) begin
                        state_reg   <= st_fetch;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= cur_addr_reg[ADDR_BITS-1:LOG_BLOCK_DATA_BYTES];
                    end
                end
                st_fetch: begin
                    // SRAM read issued this cycle; data arrives next cycle.
                    state_reg <= st_capture;
                end
                st_capture: begin
                    s_r_data  <= mem_rd_data;
                    s_r_valid <= 1'b1;
                    s_r_last  <= (beats_left_reg == '0);
                    s_r_id    <= cur_id_reg;
                    state_reg <= st_resp;
                end
                st_resp: begin
                    // Beat held stable until the master accepts it.
                    if (s_r_ready) begin
                        s_r_valid      <= 1'b0;
                        cur_addr_reg   <= cur_addr_next;
                        beats_left_reg <= beats_left_reg - BURST_LEN_WIDTH'(1);
                        if (beats_left_reg != '0) begin
                            state_reg   <= st_fetch;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= cur_addr_next[ADDR_BITS-1:LOG_BLOCK_DATA_BYTES];
                        end else begin
                            state_reg <= st_idle;
                        end
                    end
                end
                default: begin
                    state_reg <= st_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed testbench for axi_rd_responder: behavioural SRAM, event monitor
// logging reads and R beats with cycle stamps, and hand-computed expectations.
module tb_axi_rd_responder;

    localparam int BW  = 512;
    localparam int BAW = 58;

    logic            clk;
    logic            resetN;
    logic            s_ar_valid;
    logic            s_ar_ready;
    logic [63:0]     s_ar_addr;
    logic [7:0]      s_ar_len;
    logic [7:0]      s_ar_id;
    logic            s_r_valid;
    logic            s_r_ready;
    logic [BW-1:0]   s_r_data;
    logic [7:0]      s_r_id;
    logic            s_r_last;
    logic            mem_rd_en;
    logic [BAW-1:0]  mem_rd_addr;
    logic [BW-1:0]   mem_rd_data;
    logic [7:0]      respLatency;
    logic [2:0]      queueCnt;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int ar_cyc = 0;
    int rv_start = 0;
    logic rv_prev = 1'b0;

    int             rd_cyc_q[$];
    logic [BAW-1:0] rd_addr_q[$];
    int             beat_cyc_q[$];
    logic [7:0]     beat_id_q[$];
    logic           beat_last_q[$];
    logic [BW-1:0]  beat_data_q[$];

    axi_rd_responder dut (
        .clk         (clk),
        .resetN      (resetN),
        .s_ar_valid  (s_ar_valid),
        .s_ar_ready  (s_ar_ready),
        .s_ar_addr   (s_ar_addr),
        .s_ar_len    (s_ar_len),
        .s_ar_id     (s_ar_id),
        .s_r_valid   (s_r_valid),
        .s_r_ready   (s_r_ready),
        .s_r_data    (s_r_data),
        .s_r_id      (s_r_id),
        .s_r_last    (s_r_last),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .respLatency (respLatency),
        .queueCnt    (queueCnt),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Deterministic SRAM contents derived from the block index.
    function automatic logic [BW-1:0] mem_word(input logic [BAW-1:0] a);
        logic [63:0] w;
        w = {6'h0, a} ^ 64'hA5A5_1234_0000_5A5A;
        return {8{w}};
    endfunction

    // SRAM model: data only valid the cycle after a strobe, junk otherwise.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_word(mem_rd_addr);
        else           mem_rd_data <= {16{32'hDEADBEEF}};
    end

    // Event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (resetN) begin
            if (s_ar_valid && s_ar_ready) begin
                ar_cyc = cyc;
                $display("[%0d] AR id=%0d addr=%0h len=%0d", cyc, s_ar_id, s_ar_addr, s_ar_len);
            end
            if (mem_rd_en) begin
                rd_cyc_q.push_back(cyc);
                rd_addr_q.push_back(mem_rd_addr);
            end
            if (s_r_valid && !rv_prev) rv_start = cyc;
            if (s_r_valid && s_r_ready) begin
                beat_cyc_q.push_back(rv_start);
                beat_id_q.push_back(s_r_id);
                beat_last_q.push_back(s_r_last);
                beat_data_q.push_back(s_r_data);
                $display("[%0d] R  id=%0d last=%0d data[63:0]=%0h", cyc, s_r_id, s_r_last, s_r_data[63:0]);
            end
        end
        rv_prev = resetN && s_r_valid;
    end

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        rd_cyc_q.delete();
        rd_addr_q.delete();
        beat_cyc_q.delete();
        beat_id_q.delete();
        beat_last_q.delete();
        beat_data_q.delete();
    endtask

    task automatic send_ar(input logic [63:0] addr, input logic [7:0] len, input logic [7:0] id);
        int   w;
        logic acc;
        w = 0;
        acc = 1'b0;
        s_ar_addr  = addr;
        s_ar_len   = len;
        s_ar_id    = id;
        s_ar_valid = 1'b1;
        while (!acc && w < 200) begin
            @(negedge clk);
            acc = s_ar_ready;
            @(posedge clk);
            #1;
            w++;
        end
        s_ar_valid = 1'b0;
        chk($sformatf("ar_accept_id%0d", id), acc, 1);
    endtask

    task automatic wait_idle();
        int   w;
        logic idle;
        w = 0;
        idle = 1'b0;
        while (!idle && w < 300) begin
            @(negedge clk);
            idle = !busy && !s_r_valid;
            @(posedge clk);
            #1;
            w++;
        end
        chk("idle_timeout", idle, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   nlast;
        resetN      = 1'b0;
        s_ar_valid  = 1'b0;
        s_ar_addr   = '0;
        s_ar_len    = '0;
        s_ar_id     = '0;
        s_r_ready   = 1'b0;
        respLatency = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ar_ready", s_ar_ready, 0);
        chk("rst_r_valid",  s_r_valid,  0);
        chk("rst_qcnt",     queueCnt,   0);
        chk("rst_busy",     busy,       0);
        chk("rst_rd_en",    mem_rd_en,  0);
        chk("rst_r_last",   s_r_last,   0);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_ready_after_rst", s_ar_ready, 1);

        // 1) single beat, zero latency
        clear_logs();
        s_r_ready = 1'b1;
        send_ar(64'h1000, 8'd0, 8'd5);
        wait_idle();
        chk("t1_nrd",     rd_cyc_q.size(), 1);
        chk("t1_rd_cyc",  rd_cyc_q[0] - ar_cyc, 2);
        chk("t1_rd_addr", rd_addr_q[0], 58'h40);
        chk("t1_nbeat",   beat_id_q.size(), 1);
        chk("t1_rv_cyc",  beat_cyc_q[0] - ar_cyc, 4);
        chk("t1_id",      beat_id_q[0], 5);
        chk("t1_last",    beat_last_q[0], 1);
        chk("t1_data",    beat_data_q[0], mem_word(58'h40));

        // 2) 4-beat burst, latency 4; latency change mid-wait must not matter
        clear_logs();
        respLatency = 8'd4;
        send_ar(64'h2000, 8'd3, 8'd2);
        @(posedge clk);
        #1;
        respLatency = 8'd9;
        wait_idle();
        respLatency = 8'd0;
        chk("t2_nrd",   rd_cyc_q.size(), 4);
        chk("t2_nbeat", beat_id_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_rd_cyc%0d", i),  rd_cyc_q[i] - ar_cyc, 6 + 3 * i);
            chk($sformatf("t2_rd_addr%0d", i), rd_addr_q[i], 58'h80 + i);
            chk($sformatf("t2_rv_cyc%0d", i),  beat_cyc_q[i] - ar_cyc, 8 + 3 * i);
            chk($sformatf("t2_id%0d", i),      beat_id_q[i], 2);
            chk($sformatf("t2_last%0d", i),    beat_last_q[i], (i == 3) ? 1 : 0);
            chk($sformatf("t2_data%0d", i),    beat_data_q[i], mem_word(58'h80 + i));
        end

        // 3) back-pressure on first beat of a 2-beat burst
        clear_logs();
        s_r_ready = 1'b0;
        send_ar(64'h3000, 8'd1, 8'd7);
        n = 0;
        @(negedge clk);
        while (!s_r_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t3_valid_seen", s_r_valid, 1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_hold_valid%0d", k), s_r_valid, 1);
            chk($sformatf("t3_hold_data%0d", k),  s_r_data, mem_word(58'hC0));
            chk($sformatf("t3_hold_id%0d", k),    s_r_id, 7);
            chk($sformatf("t3_hold_last%0d", k),  s_r_last, 0);
            chk($sformatf("t3_no_rd%0d", k),      mem_rd_en, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        s_r_ready = 1'b1;
        wait_idle();
        chk("t3_nrd",      rd_cyc_q.size(), 2);
        chk("t3_rd2_cyc",  rd_cyc_q[1] - ar_cyc, 11);
        chk("t3_rd2_addr", rd_addr_q[1], 58'hC1);
        chk("t3_nbeat",    beat_id_q.size(), 2);
        chk("t3_last2",    beat_last_q[1], 1);
        chk("t3_data2",    beat_data_q[1], mem_word(58'hC1));

        // 4) queue fills while R is stalled; order preserved
        clear_logs();
        s_r_ready  = 1'b0;
        s_ar_len   = 8'd0;
        s_ar_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            s_ar_id   = 8'(k);
            s_ar_addr = 64'h6000 + 64'(k * 64);
            @(negedge clk);
            chk($sformatf("t4_ready_id%0d", k), s_ar_ready, 1);
            @(posedge clk);
            #1;
        end
        s_ar_id   = 8'd6;
        s_ar_addr = 64'h6000 + 64'(6 * 64);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t4_full_ready%0d", k), s_ar_ready, 0);
            chk($sformatf("t4_full_qcnt%0d", k),  queueCnt, 4);
            @(posedge clk);
            #1;
        end
        s_r_ready = 1'b1;
        send_ar(64'h6000 + 64'(6 * 64), 8'd0, 8'd6);
        wait_idle();
        chk("t4_nbeat", beat_id_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t4_order%0d", i), beat_id_q[i], i + 1);
            chk($sformatf("t4_data%0d", i),  beat_data_q[i], mem_word(58'h181 + i));
            chk($sformatf("t4_last%0d", i),  beat_last_q[i], 1);
        end

        // 5) address wrap at the top of the address space
        clear_logs();
        send_ar(64'hFFFF_FFFF_FFFF_FFC0, 8'd1, 8'd3);
        wait_idle();
        chk("t5_nrd",      rd_addr_q.size(), 2);
        chk("t5_rd_addr0", rd_addr_q[0], 58'h3FF_FFFF_FFFF_FFFF);
        chk("t5_rd_addr1", rd_addr_q[1], 58'h0);
        chk("t5_data1",    beat_data_q[1], mem_word(58'h0));
        chk("t5_last0",    beat_last_q[0], 0);
        chk("t5_last1",    beat_last_q[1], 1);

        // 6) reset during beat 2 of an 8-beat burst with two queued requests
        clear_logs();
        s_r_ready = 1'b1;
        send_ar(64'h4000, 8'd7, 8'd8);
        send_ar(64'h4400, 8'd0, 8'd9);
        send_ar(64'h4800, 8'd0, 8'd10);
        n = 0;
        while (beat_id_q.size() < 1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_beat1_seen", beat_id_q.size(), 1);
        s_r_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!s_r_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_beat2_valid", s_r_valid, 1);
        chk("t6_qcnt_pre",    queueCnt, 2);
        @(posedge clk);
        #1;
        resetN = 1'b0;
        #1;
        chk("t6_rst_r_valid", s_r_valid,  0);
        chk("t6_rst_qcnt",    queueCnt,   0);
        chk("t6_rst_busy",    busy,       0);
        chk("t6_rst_rd_en",   mem_rd_en,  0);
        chk("t6_rst_ready",   s_ar_ready, 0);
        nlast = 0;
        foreach (beat_last_q[i]) if (beat_last_q[i]) nlast++;
        chk("t6_no_last", nlast, 0);
        repeat (2) @(posedge clk);
        #1;
        s_r_ready = 1'b1;
        resetN = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_ready_after_rst", s_ar_ready, 1);
        clear_logs();
        send_ar(64'h5000, 8'd0, 8'd11);
        wait_idle();
        chk("t6_nbeat",    beat_id_q.size(), 1);
        chk("t6_id",       beat_id_q[0], 11);
        chk("t6_last",     beat_last_q[0], 1);
        chk("t6_data",     beat_data_q[0], mem_word(58'h140));
        chk("t6_rd_addr",  rd_addr_q[0], 58'h140);
        chk("t6_rv_cyc",   beat_cyc_q[0] - ar_cyc, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
